// File: rtl/rca_seq_pkg.sv
// Shared definitions for the data-loop sequencer: opcodes, FSM states,
// instruction field positions and the decoded control bundle.
package rca_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_OR   = 4'h3,
        OP_LDI  = 4'h4,
        OP_ADDI = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_JC   = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RC_MSB  = 11;
    localparam int RC_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // EnX enables operand X; ImmEnX swaps the register value for the immediate.
    typedef struct packed {
        logic en_a;
        logic imm_en_a;
        logic inv_a;
        logic en_b;
        logic imm_en_b;
        logic inv_b;
        logic c_in;
        logic or_en;
        logic flood_carry;
        logic reg_write;
        logic jmp;
        logic jz;
        logic jc;
        logic halt;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/rca_seq_decode.sv
// Combinational opcode decoder: maps the 4-bit opcode onto the data-loop
// control bundle plus sequencing hints (branch kind, halt, illegal).
module rca_seq_decode
    import rca_seq_pkg::*;
(
    input  logic [3:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin
                ctrl.en_a      = 1'b1;
                ctrl.en_b      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_SUB: begin
                ctrl.en_a      = 1'b1;
                ctrl.en_b      = 1'b1;
                ctrl.inv_b     = 1'b1;
                ctrl.c_in      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_OR: begin
                ctrl.en_a      = 1'b1;
                ctrl.en_b      = 1'b1;
                ctrl.or_en     = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_LDI: begin
                ctrl.en_a      = 1'b1;
                ctrl.imm_en_a  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl.en_a      = 1'b1;
                ctrl.en_b      = 1'b1;
                ctrl.imm_en_b  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OP_JMP:  ctrl.jmp  = 1'b1;
            OP_JZ:   ctrl.jz   = 1'b1;
            OP_JC:   ctrl.jc   = 1'b1;
            OP_HALT: ctrl.halt = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rca_dataloop_sequencer.sv
// Two-cycle fetch/execute sequencer for the ripple-carry data loop.
// Owns the FSM, program counter, Z/C flags and sticky illegal status.
module rca_dataloop_sequencer
    import rca_seq_pkg::*;
#(
    parameter int BitWidth     = 8,
    parameter int RegAddrWidth = 4,
    parameter int PcWidth      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    start,
    output logic [PcWidth-1:0]      pc,
    output logic                    instr_rd_en,
    input  logic [INSTR_W-1:0]      instr,
    input  logic                    cOut,
    input  logic                    ifZero,
    output logic                    EnA,
    output logic                    ImmEnA,
    output logic                    InvA,
    output logic                    EnB,
    output logic                    ImmEnB,
    output logic                    InvB,
    output logic                    cIn,
    output logic                    ORen,
    output logic                    FloodCarry,
    output logic                    RegWriteEn,
    output logic [RegAddrWidth-1:0] regAAddr,
    output logic [RegAddrWidth-1:0] regBAddr,
    output logic [RegAddrWidth-1:0] regCAddr,
    output logic [BitWidth-1:0]     ImmIN,
    output logic                    halted,
    output logic                    illegal
);

    state_e               state_q, state_d;
    logic [PcWidth-1:0]   pc_q, pc_d;
    logic                 z_q, z_d;
    logic                 c_q, c_d;
    logic                 illegal_q, illegal_d;
    ctrl_t                ctrl;
    logic                 taken;

    rca_seq_decode u_decode (
        .op   (instr[OP_MSB:OP_LSB]),
        .ctrl (ctrl)
    );

    assign taken = ctrl.jmp | (ctrl.jz & z_q) | (ctrl.jc & c_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        z_d         = z_q;
        c_d         = c_q;
        illegal_d   = illegal_q;
        instr_rd_en = 1'b0;
        EnA         = 1'b0;
        ImmEnA      = 1'b0;
        InvA        = 1'b0;
        EnB         = 1'b0;
        ImmEnB      = 1'b0;
        InvB        = 1'b0;
        cIn         = 1'b0;
        ORen        = 1'b0;
        FloodCarry  = 1'b0;
        RegWriteEn  = 1'b0;
        regAAddr    = '0;
        regBAddr    = '0;
        regCAddr    = '0;
        ImmIN       = '0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                instr_rd_en = 1'b1;
                state_d     = ST_EXEC;
            end
            ST_EXEC: begin
                EnA        = ctrl.en_a;
                ImmEnA     = ctrl.imm_en_a;
                InvA       = ctrl.inv_a;
                EnB        = ctrl.en_b;
                ImmEnB     = ctrl.imm_en_b;
                InvB       = ctrl.inv_b;
                cIn        = ctrl.c_in;
                ORen       = ctrl.or_en;
                FloodCarry = ctrl.flood_carry;
                // A reset landing on this edge must not let the shared data loop commit.
                RegWriteEn = ctrl.reg_write & ~rst;
                regCAddr   = RegAddrWidth'(instr[RC_MSB:RC_LSB]);
                regAAddr   = RegAddrWidth'(instr[RA_MSB:RA_LSB]);
                regBAddr   = RegAddrWidth'(instr[RB_MSB:RB_LSB]);
                ImmIN      = BitWidth'(instr[IMM_MSB:IMM_LSB]);

                if (ctrl.reg_write) begin
                    z_d = ifZero;
                    c_d = cOut;
                end
                pc_d      = taken ? PcWidth'(instr[IMM_MSB:IMM_LSB]) : pc_q + PcWidth'(1);
                illegal_d = illegal_q | ctrl.illegal;
                state_d   = ctrl.halt ? ST_HALT : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            z_q       <= z_d;
            c_q       <= c_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc      = pc_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_rca_dataloop_sequencer.sv
// Self-checking bench: directed programs plus a random run, compared each
// cycle against an instruction-level reference model of the sequencer.
module tb_rca_dataloop_sequencer;

    logic        clk = 1'b0;
    logic        rst, clk_en, start, cOut, ifZero;
    logic [7:0]  pc;
    logic        instr_rd_en;
    logic [15:0] instr = '0;
    logic        EnA, ImmEnA, InvA, EnB, ImmEnB, InvB, cIn, ORen, FloodCarry, RegWriteEn;
    logic [3:0]  regAAddr, regBAddr, regCAddr;
    logic [7:0]  ImmIN;
    logic        halted, illegal;

    logic [15:0] rom [256];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  wq [$];

    // reference model state
    typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT} mph_e;
    mph_e        m_ph;
    logic [7:0]  m_pc;
    logic        m_z, m_c, m_ill;
    logic        m_valid = 1'b0;

    rca_dataloop_sequencer dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
        .pc(pc), .instr_rd_en(instr_rd_en), .instr(instr),
        .cOut(cOut), .ifZero(ifZero),
        .EnA(EnA), .ImmEnA(ImmEnA), .InvA(InvA), .EnB(EnB), .ImmEnB(ImmEnB),
        .InvB(InvB), .cIn(cIn), .ORen(ORen), .FloodCarry(FloodCarry),
        .RegWriteEn(RegWriteEn),
        .regAAddr(regAAddr), .regBAddr(regBAddr), .regCAddr(regCAddr),
        .ImmIN(ImmIN), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // synchronous instruction ROM
    always @(posedge clk) if (instr_rd_en) instr <= rom[pc];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {EnA,ImmEnA,InvA,EnB,ImmEnB,InvB,cIn,ORen,FloodCarry,RegWriteEn}
    function automatic logic [9:0] exp_ctl(input logic [3:0] op);
        case (op)
            4'h1:    return 10'b1_0_0_1_0_0_0_0_0_1;
            4'h2:    return 10'b1_0_0_1_0_1_1_0_0_1;
            4'h3:    return 10'b1_0_0_1_0_0_0_1_0_1;
            4'h4:    return 10'b1_1_0_0_0_0_0_0_0_1;
            4'h5:    return 10'b1_0_0_1_1_0_0_0_0_1;
            default: return 10'b0;
        endcase
    endfunction

    task automatic tick(input logic r, input logic en, input logic st, input logic zf, input logic cf);
        logic [15:0] w;
        logic [9:0]  ctl;
        logic        ex, taken;
        logic [3:0]  op;
        rst = r; clk_en = en; start = st; ifZero = zf; cOut = cf;
        #1;
        w  = rom[m_pc];
        op = w[15:12];
        ex = (m_ph == M_EXEC);
        if (m_valid) begin
            ctl = ex ? exp_ctl(op) : 10'b0;
            if (r) ctl[0] = 1'b0;
            chk("pc", pc, m_pc);
            chk("instr_rd_en", instr_rd_en, m_ph == M_FETCH);
            chk("halted", halted, m_ph == M_HALT);
            chk("illegal", illegal, m_ill);
            chk("ctl", {EnA, ImmEnA, InvA, EnB, ImmEnB, InvB, cIn, ORen, FloodCarry, RegWriteEn}, ctl);
            chk("addr", {regCAddr, regAAddr, regBAddr}, ex ? w[11:0] : 12'h0);
            chk("ImmIN", ImmIN, ex ? w[7:0] : 8'h0);
        end
        if (RegWriteEn && en) wq.push_back(regCAddr);
        if (r) begin
            m_ph = M_IDLE; m_pc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0; m_valid = 1'b1;
        end else if (en && m_valid) begin
            case (m_ph)
                M_IDLE, M_HALT: if (st) m_ph = M_FETCH;
                M_FETCH: m_ph = M_EXEC;
                M_EXEC: begin
                    taken = (op == 4'h6) || (op == 4'h7 && m_z) || (op == 4'h8 && m_c);
                    if (op >= 4'h1 && op <= 4'h5) begin m_z = zf; m_c = cf; end
                    if (op >= 4'h9 && op <= 4'hE) m_ill = 1'b1;
                    m_pc = taken ? w[7:0] : 8'((int'(m_pc) + 1) % 256);
                    m_ph = (op == 4'hF) ? M_HALT : M_FETCH;
                end
                default: m_ph = M_IDLE;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go(input int n, input logic zf, input logic cf);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, zf, cf);
    endtask

    task automatic reset_clear();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        wq.delete();
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; ifZero = 1'b0; cOut = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        @(negedge clk);

        // LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT
        reset_clear();
        rom[0] = 16'h4105; rom[1] = 16'h4203; rom[2] = 16'h1312; rom[3] = 16'hF000;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(8, 1'b0, 1'b0);
        chk("ldi_add_pc", pc, 8'h04);
        chk("ldi_add_halted", halted, 1'b1);
        chk("ldi_add_writes", wq.size(), 3);
        if (wq.size() == 3) chk("ldi_add_rc", {wq[0], wq[1], wq[2]}, 12'h123);

        // SUB then JZ, taken and not taken
        for (int k = 0; k < 2; k++) begin
            reset_clear();
            rom[0] = 16'h2311; rom[1] = 16'h7020; rom[2] = 16'hF000; rom[8'h20] = 16'hF000;
            tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            go(6, (k == 0), 1'b0);
            chk("jz_pc", pc, (k == 0) ? 8'h21 : 8'h03);
        end

        // PC wrap from 0xFF
        reset_clear();
        rom[0] = 16'h60FF; rom[8'hFF] = 16'h0000;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(4, 1'b0, 1'b0);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_fetch", instr_rd_en, 1'b1);

        // illegal opcode is sticky until reset
        reset_clear();
        rom[0] = 16'hA123; rom[1] = 16'hF000;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(4, 1'b0, 1'b0);
        chk("illegal_set", illegal, 1'b1);
        chk("illegal_nowrite", wq.size(), 0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(2, 1'b0, 1'b0);
        chk("illegal_sticky", illegal, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("illegal_rst", illegal, 1'b0);

        // HALT at 4, resume at 5
        reset_clear();
        rom[4] = 16'hF000; rom[5] = 16'h4107; rom[6] = 16'hF000;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(12, 1'b0, 1'b0);
        chk("halt_pc", pc, 8'h05);
        chk("halt_flag", halted, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("resume_fetch", instr_rd_en, 1'b1);
        chk("resume_pc", pc, 8'h05);

        // reset mid-EXEC of ADD, then clk_en low in FETCH
        reset_clear();
        rom[0] = 16'h1312;
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        go(1, 1'b0, 1'b0);
        chk("exec_before_rst", RegWriteEn, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_nowrite", RegWriteEn, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_idle", {instr_rd_en, halted}, 2'b00);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("hold_fetch", instr_rd_en, 1'b1);
        chk("hold_pc", pc, 8'h00);
        go(2, 1'b0, 1'b0);
        chk("hold_resume_pc", pc, 8'h01);

        // random programs, enables, starts and resets
        reset_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 100) == 0, ($urandom % 5) != 0, ($urandom % 8) == 0,
                 1'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rca_dataloop_sequencer.md
RCA_DATALOOP_SEQUENCER -- requirements
Module: rca_dataloop_sequencer

Interface
REQ-001 SHALL have parameter BitWidth, default 8, datapath width driven to the data loop.
REQ-002 SHALL have parameter RegAddrWidth, default 4, register address width.
REQ-003 SHALL have parameter PcWidth, default 8, program counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port clk_en  input  1  when 0, all state holds.
REQ-007 SHALL have port start  input  1  leave IDLE/HALT and begin fetching at PC.
REQ-008 SHALL have port pc  output  PcWidth  instruction memory address.
REQ-009 SHALL have port instr_rd_en  output  1  instruction memory read strobe.
REQ-010 SHALL have port instr  input  16  instruction word, valid one cycle after instr_rd_en (synchronous ROM).
REQ-011 SHALL have ports cOut, ifZero  input  1 each  data loop flags.
REQ-012 SHALL have ports EnA, ImmEnA, InvA, EnB, ImmEnB, InvB, cIn, ORen, FloodCarry, RegWriteEn  output  1 each  data loop controls.
REQ-013 SHALL have ports regAAddr, regBAddr, regCAddr  output  RegAddrWidth each; ImmIN  output  BitWidth.
REQ-014 SHALL have ports halted, illegal  output  1 each  status.

Function
REQ-015 Instruction fields: op=instr[15:12], rC=[11:8], rA=[7:4], rB=[3:0], imm=[7:0] zero-extended/truncated to BitWidth.
REQ-016 States: IDLE, FETCH, EXEC, HALT; rst -> IDLE.
REQ-017 IDLE/HALT: start=1 -> FETCH; else hold.
REQ-018 FETCH: instr_rd_en=1, all data loop controls 0; next EXEC.
REQ-019 EXEC: decode instr combinationally, drive controls for one cycle; next FETCH, or HALT for op F.
REQ-020 Opcodes: 0 NOP; 1 ADD rC=rA+rB; 2 SUB rC=rA+~rB+1 (InvB,cIn); 3 OR (ORen); 4 LDI rC=imm (ImmEnA, EnB=0); 5 ADDI rC=rA+imm (ImmEnB); 6 JMP; 7 JZ; 8 JC; F HALT.
REQ-021 RegWriteEn=1 only in EXEC of ops 1-5.
REQ-022 Flag registers Z,C SHALL capture ifZero,cOut at end of EXEC of ops 1-5 only.
REQ-023 PC update in EXEC: JMP, JZ with Z=1, JC with C=1 -> pc=imm[PcWidth-1:0]; else pc+1, wrapping 2^PcWidth-1 -> 0.
REQ-024 Opcodes 9-E SHALL execute as NOP and set sticky illegal, cleared only by rst.
REQ-025 Throughput: one instruction per 2 enabled cycles; flags from instruction N visible to branch N+1.
REQ-026 clk_en=0 mid-instruction: state, PC, flags hold; outputs keep current-state values, RegWriteEn must not double-write (data loop shares clk_en).
REQ-027 halted=1 exactly in HALT state; start in HALT resumes at pc+1 of HALT instruction.
REQ-028 start ignored in FETCH/EXEC.

Reset
REQ-029 rst (sync, priority over clk_en) SHALL set state IDLE, pc=0, Z=0, C=0, illegal=0, halted=0.
REQ-030 All control outputs, ImmIN, addresses, instr_rd_en SHALL be 0 in the cycle after rst; reset mid-EXEC aborts without write.

Structure
REQ-031 Opcode enum, state enum and field-position constants SHALL live in a shared package rca_seq_pkg.
REQ-032 One sub-module rca_seq_decode (combinational op -> control-line bundle) is natural; FSM/PC/flags remain in top.

Verification
REQ-033 LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> RegWriteEn on each EXEC, regCAddr 1,2,3, ImmIN 5 then 3, pc 0->3.
REQ-034 SUB r3,r1,r1 with ifZero=1 then JZ 0x20 -> pc=0x20; same with ifZero=0 -> pc increments.
REQ-035 pc=0xFF executing NOP -> pc wraps to 0x00.
REQ-036 Opcode 0xA -> no RegWriteEn, illegal=1 persisting until rst.
REQ-037 HALT at pc=4 -> halted=1, pc holds 5; start -> FETCH at 5.
REQ-038 rst asserted during EXEC of ADD -> no RegWriteEn next cycle, pc=0, state IDLE; clk_en low 3 cycles in FETCH -> all state held.
